// File: rtl/inst_rom_resp.sv
// Instruction ROM with a side load port and a fixed-latency, single-outstanding
// fetch response (ack/inst/err) after WAIT_CYCLES wait states.
module inst_rom_resp #(
  parameter int DEPTH       = 64,
  parameter int AW          = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          req,
  input  logic [31:0]   addr,
  output logic          ack,
  output logic [31:0]   inst,
  output logic          err,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic [31:0]   addr_q;
  logic          ack_q;
  logic [31:0]   inst_q;
  logic          err_q;
  logic [31:0]   mem_q [DEPTH];

  logic [31:0]   addr_sel;
  logic [AW-1:0] idx_sel;
  logic [31:0]   inst_d;
  logic          err_d;

  // With zero wait states the response is loaded straight from the live address.
  always_comb begin
    addr_sel = (state_q == IDLE) ? addr : addr_q;
    idx_sel  = addr_sel[AW+1:2];
    err_d    = (addr_sel[1:0] != 2'b00) || (|addr_sel[31:AW+2]);
    inst_d   = err_d ? 32'h0 : mem_q[idx_sel];
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
      ack_q   <= 1'b0;
      inst_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= 1'b0;
          if (ce && req) begin
            addr_q <= addr;
            if (WAIT_CYCLES == 0) begin
              state_q <= RESP;
              ack_q   <= 1'b1;
              inst_q  <= inst_d;
              err_q   <= err_d;
            end else begin
              state_q <= WAIT;
              cnt_q   <= 4'(WAIT_CYCLES);
            end
          end
        end
        WAIT: begin
          if (!ce) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
          end else if (cnt_q == 4'd1) begin
            state_q <= RESP;
            cnt_q   <= 4'd0;
            ack_q   <= 1'b1;
            inst_q  <= inst_d;
            err_q   <= err_d;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
          ack_q   <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  assign ack  = ack_q;
  assign inst = inst_q;
  assign err  = err_q;

endmodule

// File: tb/tb_inst_rom_resp.sv
// Scoreboard bench: two instances (2 and 0 wait states) driven with directed
// and random fetches; responses checked against a word-array reference model.
module tb_inst_rom_resp;

  typedef struct {
    int          due;
    logic [31:0] inst;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_s   [2];
  logic        ce_s    [2];
  logic        req_s   [2];
  logic [31:0] addr_s  [2];
  logic        ack_s   [2];
  logic [31:0] inst_s  [2];
  logic        err_s   [2];
  logic        we_s    [2];
  logic [5:0]  waddr_s [2];
  logic [31:0] wdata_s [2];

  exp_t        sb  [2][$];
  logic [31:0] mdl [2][64];
  int          cyc      = 0;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wc(int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: misaligned or beyond the 64-word range -> error with zero data.
  task automatic push(int d, logic [31:0] a, int due);
    exp_t e;
    e.due = due;
    if ((a % 4) != 0 || a >= 32'd256) begin
      e.inst = 32'h0;
      e.err  = 1'b1;
    end else begin
      e.inst = mdl[d][a / 4];
      e.err  = 1'b0;
    end
    sb[d].push_back(e);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    exp_t        e;
    logic [31:0] last_inst = 32'h0;
    logic        last_err  = 1'b0;

    inst_rom_resp #(.DEPTH(64), .AW(6), .WAIT_CYCLES(g == 0 ? 2 : 0)) u_dut (
      .clk  (clk),
      .rst  (rst_s[g]),
      .ce   (ce_s[g]),
      .req  (req_s[g]),
      .addr (addr_s[g]),
      .ack  (ack_s[g]),
      .inst (inst_s[g]),
      .err  (err_s[g]),
      .we   (we_s[g]),
      .waddr(waddr_s[g]),
      .wdata(wdata_s[g])
    );

    always @(negedge clk) begin
      if (!rst_s[g]) begin
        chk("rst_ack", 32'(ack_s[g]), 32'h0);
        chk("rst_inst", inst_s[g], 32'h0);
        chk("rst_err", 32'(err_s[g]), 32'h0);
        last_inst = 32'h0;
        last_err  = 1'b0;
      end else if (ack_s[g]) begin
        if (sb[g].size() == 0) begin
          chk("unexpected_ack", 32'(ack_s[g]), 32'h0);
        end else begin
          e = sb[g].pop_front();
          chk("ack_cycle", 32'(cyc), 32'(e.due));
          chk("inst", inst_s[g], e.inst);
          chk("err", 32'(err_s[g]), 32'(e.err));
          last_inst = e.inst;
          last_err  = e.err;
        end
      end else begin
        if (sb[g].size() != 0 && sb[g][0].due < cyc) begin
          chk("missing_ack", 32'(ack_s[g]), 32'h1);
          void'(sb[g].pop_front());
        end
        chk("hold_inst", inst_s[g], last_inst);
        chk("hold_err", 32'(err_s[g]), 32'(last_err));
      end
    end
  end

  task automatic wr(int d, int idx, logic [31:0] data);
    @(negedge clk);
    we_s[d] = 1'b1; waddr_s[d] = 6'(idx); wdata_s[d] = data;
    @(negedge clk);
    we_s[d] = 1'b0;
    mdl[d][idx] = data;
  endtask

  task automatic fetch(int d, logic [31:0] a, bit ce_v);
    @(negedge clk);
    req_s[d] = 1'b1; addr_s[d] = a; ce_s[d] = ce_v;
    if (ce_v) push(d, a, cyc + 1 + wc(d));
    @(negedge clk);
    req_s[d] = 1'b0; ce_s[d] = 1'b1;
    repeat (wc(d) + 1) @(negedge clk);
  endtask

  initial begin
    logic [31:0] a;
    int r;
    for (int d = 0; d < 2; d++) begin
      rst_s[d] = 1'b0; ce_s[d] = 1'b1; req_s[d] = 1'b0; addr_s[d] = 32'h0;
      we_s[d] = 1'b0; waddr_s[d] = 6'd0; wdata_s[d] = 32'h0;
    end
    // Preload both arrays while held in reset; contents survive reset.
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        we_s[d] = 1'b1; waddr_s[d] = 6'(i);
        wdata_s[d] = (i == 3) ? 32'h3401_1100 : $urandom;
        mdl[d][i] = wdata_s[d];
      end
    end
    @(negedge clk);
    we_s[0] = 1'b0; we_s[1] = 1'b0;
    rst_s[0] = 1'b1; rst_s[1] = 1'b1;

    fetch(0, 32'h0000_000C, 1'b1);
    fetch(0, 32'h0000_0102, 1'b1);
    fetch(0, 32'h0000_0100, 1'b1);

    // Back-to-back: req held high, next address presented while busy.
    @(negedge clk);
    req_s[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      addr_s[0] = 32'(i * 4);
      push(0, addr_s[0], cyc + 1 + wc(0));
      if (i < 2) repeat (wc(0) + 2) @(negedge clk);
    end
    @(negedge clk);
    req_s[0] = 1'b0;
    repeat (wc(0) + 1) @(negedge clk);

    // Abort: ce dropped in WAIT, then a normal fetch.
    fetch(0, 32'h0000_0014, 1'b1);
    @(negedge clk);
    req_s[0] = 1'b1; addr_s[0] = 32'h0000_0020;
    @(negedge clk);
    req_s[0] = 1'b0; ce_s[0] = 1'b0;
    @(negedge clk);
    ce_s[0] = 1'b1;
    repeat (4) @(negedge clk);
    fetch(0, 32'h0000_000C, 1'b1);

    // Reset mid-WAIT; outputs clear without a clock edge.
    @(negedge clk);
    req_s[0] = 1'b1; addr_s[0] = 32'h0000_0024;
    @(negedge clk);
    req_s[0] = 1'b0;
    #2 rst_s[0] = 1'b0;
    #1;
    chk("async_rst_ack", 32'(ack_s[0]), 32'h0);
    chk("async_rst_inst", inst_s[0], 32'h0);
    chk("async_rst_err", 32'(err_s[0]), 32'h0);
    repeat (3) @(negedge clk);
    rst_s[0] = 1'b1; req_s[0] = 1'b1; addr_s[0] = 32'h0000_0010;
    push(0, addr_s[0], cyc + 1 + wc(0));
    @(negedge clk);
    req_s[0] = 1'b0;
    repeat (wc(0) + 1) @(negedge clk);

    // Write collision on the zero-wait instance.
    wr(1, 1, 32'h0000_0001);
    @(negedge clk);
    req_s[1] = 1'b1; addr_s[1] = 32'h0000_0004;
    we_s[1] = 1'b1; waddr_s[1] = 6'd1; wdata_s[1] = 32'hFFFF_FFFF;
    push(1, addr_s[1], cyc + 1 + wc(1));
    mdl[1][1] = 32'hFFFF_FFFF;
    @(negedge clk);
    req_s[1] = 1'b0; we_s[1] = 1'b0;
    repeat (wc(1) + 1) @(negedge clk);
    fetch(1, 32'h0000_0004, 1'b1);

    for (int d = 0; d < 2; d++) begin
      for (int it = 0; it < 60; it++) begin
        r = $urandom_range(0, 9);
        if (r < 6)      a = 32'($urandom_range(0, 63)) * 4;
        else if (r < 8) a = (32'($urandom_range(0, 63)) * 4) | 32'($urandom_range(1, 3));
        else            a = ($urandom & ~32'h3) | (32'h100 << $urandom_range(0, 23));
        if ($urandom_range(0, 4) == 0) wr(d, $urandom_range(0, 63), $urandom);
        fetch(d, a, $urandom_range(0, 9) != 0);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end

    repeat (20) @(negedge clk);
    for (int d = 0; d < 2; d++) chk("sb_drained", 32'(sb[d].size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
